pipe_hazard_ctl: RTL and testbench
==================================

Name: pipe_hazard_ctl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline.
- Generalises the CU's forwarding and load-use logic to a configurable register-address width.
- Adds a multi-cycle multiply/divide busy tracker, HI/LO read interlock, and branch-taken IF flush.
- Sits beside the ID-stage control unit and drives the forwarding muxes, PC/IF-ID write enable, EX bubble, IF flush and the MD unit start.

Parameters:
- REG_AW, 5, register address width.
- MUL_LAT, 4, multiply latency in cycles (>=1).
- DIV_LAT, 32, divide latency in cycles (>=1).
- CNT_W, 16, width of performance counters.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous active-high reset
- id_rs  in  REG_AW  ID source register A
- id_rt  in  REG_AW  ID source register B
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_is_md  in  1  ID instruction is mult/div
- id_md_div  in  1  1=div, 0=mult (valid with id_is_md)
- id_rd_hilo  in  1  ID instruction is mfhi/mflo
- id_br_taken  in  1  branch/jump resolved taken in ID
- ern  in  REG_AW  EX destination register
- ewreg  in  1  EX writes register
- em2reg  in  1  EX is load
- mrn  in  REG_AW  MEM destination register
- mwreg  in  1  MEM writes register
- mm2reg  in  1  MEM is load
- fwda  out  2  operand A select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
- fwdb  out  2  operand B select, same encoding
- wpcir  out  1  PC and IF/ID write enable
- nop  out  1  inject bubble into ID/EX
- flush_if  out  1  kill instruction in IF/ID
- md_start  out  1  start pulse to MD unit
- md_busy  out  1  MD unit in flight
- stall_cnt  out  CNT_W  stall cycles (see Optional Feature)
- flush_cnt  out  CNT_W  flush cycles (see Optional Feature)

Behaviour:
- Reset: state IDLE, md_cnt=0, all counters 0. Outputs settle to fwda=fwdb=00, wpcir=1, nop=0, flush_if=0, md_start=0, md_busy=0.
- Forwarding is combinational, evaluated per operand X in {rs,rt}.
  - 01 if ewreg & ern!=0 & ern==X & ~em2reg.
  - Else 10 if mwreg & mrn!=0 & mrn==X & ~mm2reg.
  - Else 11 if mwreg & mrn!=0 & mrn==X & mm2reg.
  - Else 00.
  - Register 0 is never forwarded.
- load_use = em2reg & ern!=0 & ((id_use_rs & ern==id_rs) | (id_use_rt & ern==id_rt)). The use qualifiers are new behaviour.
- md_hazard = md_busy & (id_is_md | id_rd_hilo).
- stall = load_use | md_hazard. Outputs: wpcir=~stall, nop=stall.
- MD FSM has states IDLE and BUSY.
  - IDLE: md_start = id_is_md & ~load_use (combinational). On that edge, md_cnt loads (id_md_div ? DIV_LAT : MUL_LAT)-1 and the FSM moves to BUSY.
  - BUSY: md_busy=1. md_cnt decrements each cycle. When md_cnt==0, the FSM returns to IDLE at the next edge.
  - An op issued at cycle T keeps md_busy high for cycles T+1..T+LAT exactly.
  - md_start is never asserted in BUSY. A second MD op stalls in ID and issues on the first IDLE cycle.
- flush_if = id_br_taken & ~stall. A taken branch during a stall is not flushed; it re-resolves on the next non-stalled cycle.
- Simultaneous load_use and md_hazard produce a single stall cycle per cycle. Priorities are unchanged.
- Reset mid-MD operation aborts: immediate return to IDLE, md_busy=0.
- LAT=1: BUSY for exactly one cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with flush_if=1.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Test Plan:
- ern=5, ewreg=1, em2reg=0, id_rs=5 -> fwda=01. Same setup with mrn=5, mwreg=1 also present -> fwda still 01 (EX priority). ern=0 with id_rs=0 -> fwda=00.
- Load-use: em2reg=1, ern=7, id_rt=7, id_use_rt=1 -> wpcir=0, nop=1 for one cycle. Same with id_use_rt=0 -> no stall.
- Div with DIV_LAT=32 issued at cycle 10 -> md_start=1 at 10, md_busy=1 for cycles 11..42. mfhi in ID at cycle 20 stalls until cycle 43, when wpcir=1.
- Back-to-back mult (MUL_LAT=4) -> second op stalls cycles 1..4, md_start again at cycle 5. Reset asserted at cycle 2 of BUSY -> md_busy=0 immediately.
- id_br_taken=1 with no stall -> flush_if=1. id_br_taken=1 together with load_use -> flush_if=0, and flush_if=1 on the following cycle.
- With HAZ_PERF_CNT_EN and CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated). Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: forwarding select, load-use / MD interlock, IF flush and
// multi-cycle multiply/divide busy tracking for the 5-stage pipeline.
// Optional macro HAZ_PERF_CNT_EN enables saturating stall/flush counters;
// without it stall_cnt/flush_cnt are constant zero.
module pipe_hazard_ctl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_md,
    input  logic              id_md_div,
    input  logic              id_rd_hilo,
    input  logic              id_br_taken,
    input  logic [REG_AW-1:0] ern,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic [REG_AW-1:0] mrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic              wpcir,
    output logic              nop,
    output logic              flush_if,
    output logic              md_start,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Counter only ever holds LAT-1, so clog2(max LAT) bits are enough.
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t        state, state_nxt;
    logic [MW-1:0] md_cnt, md_cnt_nxt;
    logic          load_use, md_hazard, stall;

    // EX result wins over MEM; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] x);
        logic [1:0] s;
        s = 2'b00;
        if (ewreg && ern != '0 && ern == x && !em2reg)
            s = 2'b01;
        else if (mwreg && mrn != '0 && mrn == x)
            s = mm2reg ? 2'b11 : 2'b10;
        return s;
    endfunction

    // Forwarding selects and stall/flush decode
    always_comb begin
        fwda      = fwd_sel(id_rs);
        fwdb      = fwd_sel(id_rt);
        load_use  = em2reg && ern != '0 &&
                    ((id_use_rs && ern == id_rs) || (id_use_rt && ern == id_rt));
        md_hazard = md_busy && (id_is_md || id_rd_hilo);
        stall     = load_use || md_hazard;
        wpcir     = !stall;
        nop       = stall;
        flush_if  = id_br_taken && !stall;
    end

    // MD FSM next state, countdown and start pulse
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        case (state)
            IDLE: begin
                md_start = id_is_md && !load_use;
                if (md_start) begin
                    md_cnt_nxt = id_md_div ? MW'(DIV_LAT - 1) : MW'(MUL_LAT - 1);
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                md_busy = 1'b1;
                if (md_cnt == '0)
                    state_nxt = IDLE;
                else
                    md_cnt_nxt = md_cnt - MW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MD FSM state register; reset aborts an op in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating performance counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (flush_if && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: expected output vectors are queued
// as each cycle is driven and compared when sampled at the falling edge.
module tb_pipe_hazard_ctl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clock, reset;
    logic [AW-1:0] id_rs, id_rt, ern, mrn;
    logic          id_use_rs, id_use_rt, id_is_md, id_md_div, id_rd_hilo, id_br_taken;
    logic          ewreg, em2reg, mwreg, mm2reg;
    logic [1:0]    fwda, fwdb, fwda1, fwdb1;
    logic          wpcir, nop, flush_if, md_start, md_busy;
    logic          wpcir1, nop1, flush_if1, md_start1, md_busy1;
    logic [CW-1:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;

    logic [8:0]    obs;
    logic [8:0]    e;
    logic [8:0]    q[$];
    int            total, bad;

    assign obs = {fwda, fwdb, wpcir, nop, flush_if, md_start, md_busy};

    pipe_hazard_ctl #(.REG_AW(AW), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_md(id_is_md),
        .id_md_div(id_md_div), .id_rd_hilo(id_rd_hilo), .id_br_taken(id_br_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg),
        .mm2reg(mm2reg), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .nop(nop),
        .flush_if(flush_if), .md_start(md_start), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    // Latency-1 variant sharing the same inputs
    pipe_hazard_ctl #(.REG_AW(AW), .MUL_LAT(1), .DIV_LAT(1), .CNT_W(CW)) dut1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_md(id_is_md),
        .id_md_div(id_md_div), .id_rd_hilo(id_rd_hilo), .id_br_taken(id_br_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg),
        .mm2reg(mm2reg), .fwda(fwda1), .fwdb(fwdb1), .wpcir(wpcir1), .nop(nop1),
        .flush_if(flush_if1), .md_start(md_start1), .md_busy(md_busy1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic wp, input logic n, input logic fl,
                                      input logic st, input logic bz);
        return {fa, fb, wp, n, fl, st, bz};
    endfunction

    task automatic clear_in();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_is_md = 0; id_md_div = 0; id_rd_hilo = 0; id_br_taken = 0;
        ern = '0; ewreg = 0; em2reg = 0; mrn = '0; mwreg = 0; mm2reg = 0;
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b1;
        q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 0));
        @(negedge clock);
        e = q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, e); end
        total++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        @(posedge clock); #1; reset = 1'b0;
    endtask

    task automatic test_forward();
        string nm[6];
        nm = '{"fwd_ex", "fwd_ex_over_mem", "fwd_r0", "fwd_mem_alu", "fwd_mem_load", "fwd_skip_ex_load"};
        for (int i = 0; i < 6; i++) begin
            next_cyc();
            case (i)
                0: begin ern = 5; ewreg = 1; id_rs = 5; q.push_back(ex(2'b01, 2'b00, 1, 0, 0, 0, 0)); end
                1: begin ern = 5; ewreg = 1; id_rs = 5; mrn = 5; mwreg = 1;
                         q.push_back(ex(2'b01, 2'b00, 1, 0, 0, 0, 0)); end
                2: begin ewreg = 1; mwreg = 1; id_use_rs = 1;
                         q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 0)); end
                3: begin mrn = 3; mwreg = 1; id_rt = 3; id_rs = 4;
                         q.push_back(ex(2'b00, 2'b10, 1, 0, 0, 0, 0)); end
                4: begin mrn = 9; mwreg = 1; mm2reg = 1; id_rt = 9; id_rs = 9;
                         q.push_back(ex(2'b11, 2'b11, 1, 0, 0, 0, 0)); end
                default: begin ern = 6; ewreg = 1; em2reg = 1; mrn = 6; mwreg = 1; mm2reg = 1; id_rs = 6;
                         q.push_back(ex(2'b11, 2'b00, 1, 0, 0, 0, 0)); end
            endcase
            @(negedge clock);
            e = q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL %s got=%b exp=%b", nm[i], obs, e); end
        end
    endtask

    task automatic test_load_use();
        // stall with use qualifier, none without, and md_start held off by load-use
        for (int i = 0; i < 9; i++) begin
            next_cyc();
            if (i == 0 || i == 3) begin
                em2reg = 1; ewreg = 1; ern = 7; id_rt = 7; id_use_rt = 1; id_is_md = (i == 3);
                q.push_back(ex(2'b00, 2'b00, 0, 1, 0, 0, 0));
            end else if (i == 1) begin
                q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 0));
            end else if (i == 2) begin
                em2reg = 1; ewreg = 1; ern = 7; id_rt = 7; id_use_rt = 0;
                q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 0));
            end else if (i == 4) begin
                id_is_md = 1;
                q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 1, 0));
            end else begin
                q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 1));
            end
            @(negedge clock);
            e = q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL load_use_c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_div_hilo();
        // issue at k=0, busy k=1..32, mfhi from k=10 stalls until k=33
        for (int k = 0; k <= 33; k++) begin
            next_cyc();
            if (k == 0) begin
                id_is_md = 1; id_md_div = 1;
                q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 1, 0));
            end else begin
                id_rd_hilo = (k >= 10);
                q.push_back(ex(2'b00, 2'b00, !(k <= 32 && k >= 10), (k <= 32 && k >= 10), 0, 0, k <= 32));
            end
            @(negedge clock);
            e = q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL div_k%0d got=%b exp=%b", k, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        // mult at k=0, second mult stalls k=1..4 and issues at k=5; reset in its BUSY cycle 2
        for (int k = 0; k <= 7; k++) begin
            next_cyc();
            if (k <= 5) begin
                id_is_md = 1;
                if (k == 0 || k == 5) q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 1, 0));
                else                  q.push_back(ex(2'b00, 2'b00, 0, 1, 0, 0, 1));
            end else begin
                q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 1));
            end
            @(negedge clock);
            e = q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL b2b_k%0d got=%b exp=%b", k, obs, e); end
        end
        reset = 1'b1;
        q.push_back(ex(2'b00, 2'b00, 1, 0, 0, 0, 0));
        #1;
        e = q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_mid_busy got=%b exp=%b", obs, e); end
        @(posedge clock); #1; reset = 1'b0;
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            id_br_taken = 1;
            if (i == 1) begin
                em2reg = 1; ewreg = 1; ern = 7; id_rs = 7; id_use_rs = 1;
                q.push_back(ex(2'b00, 2'b00, 0, 1, 0, 0, 0));
            end else begin
                q.push_back(ex(2'b00, 2'b00, 1, 0, 1, 0, 0));
            end
            @(negedge clock);
            e = q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL branch_c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_lat1();
        logic [1:0] eq2[$];
        logic [1:0] o2;
        for (int k = 0; k <= 4; k++) begin
            next_cyc();
            id_is_md = (k == 0);
            eq2.push_back({k == 0, k == 1});
            @(negedge clock);
            o2 = {md_start1, md_busy1};
            total++;
            if (o2 !== eq2[0]) begin bad++; $display("FAIL lat1_k%0d got=%b exp=%b", k, o2, eq2[0]); end
            void'(eq2.pop_front());
        end
    endtask

    task automatic test_perf();
        logic [CW-1:0] es, ef;
`ifdef HAZ_PERF_CNT_EN
        es = 4'd15; ef = 4'd3;
`else
        es = 4'd0;  ef = 4'd0;
`endif
        next_cyc(); reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cyc();
            em2reg = 1; ewreg = 1; ern = 2; id_rs = 2; id_use_rs = 1;
        end
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            id_br_taken = 1;
        end
        next_cyc();
        @(negedge clock);
        total++;
        if (stall_cnt !== es) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, es); end
        total++;
        if (flush_cnt !== ef) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, ef); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        clear_in();
        test_reset();
        test_forward();
        test_load_use();
        test_div_hilo();
        test_back_to_back();
        test_branch();
        test_lat1();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
